// File: rtl/jtbubl_snd_mbox.sv
//------------------------------------------------------------------------------
// jtbubl_snd_mbox : main<->sound CPU mailbox with command NMI and overrun count.
// Optional command FIFO enabled by defining JTBUBL_MBOX_FIFO_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module jtbubl_snd_mbox #(
  parameter int NMI_LEN = 4,
  parameter int FIFO_AW = 2
)(
  input  logic       clk,
  input  logic       rst,
  input  logic       main_wr,
  input  logic       main_rd,
  input  logic [7:0] main_din,
  output logic [7:0] main_dout,
  output logic       main_flag,
  output logic       main_busy,
  input  logic       snd_wr,
  input  logic       snd_rd,
  input  logic [7:0] snd_din,
  output logic [7:0] snd_dout,
  output logic       snd_flag,
  input  logic       nmi_en,
  output logic       snd_nmi_n,
  output logic [7:0] ovf_cnt
);

  if (NMI_LEN < 1 || NMI_LEN > 15 || FIFO_AW < 1) begin : g_param_chk
    $error("jtbubl_snd_mbox: NMI_LEN must be 1..15 and FIFO_AW >= 1");
  end

  localparam logic [3:0] CNT_INIT = 4'(NMI_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       pend;
  logic       fire;

  // Next-state view of the command path, shared by both build variants
  logic [7:0] cmd_dout_nxt;
  logic       cmd_flag_nxt;
  logic       busy_nxt;
  logic       ovf;

`ifdef JTBUBL_MBOX_FIFO_EN
  localparam int PW    = FIFO_AW + 1;
  localparam int DEPTH = 1 << FIFO_AW;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wptr, rptr, wptr_nxt, rptr_nxt;
  logic          empty, full, pop, push;

  always_comb begin
    empty    = (wptr == rptr);
    full     = (wptr[FIFO_AW] != rptr[FIFO_AW]) &&
               (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);
    pop      = snd_rd && !empty;
    push     = main_wr && (!full || pop);
    ovf      = main_wr && !push;
    rptr_nxt = rptr + PW'(pop);
    wptr_nxt = wptr + PW'(push);
    cmd_flag_nxt = (wptr_nxt != rptr_nxt);
    busy_nxt     = (wptr_nxt[FIFO_AW] != rptr_nxt[FIFO_AW]) &&
                   (wptr_nxt[FIFO_AW-1:0] == rptr_nxt[FIFO_AW-1:0]);
    // The new head may be the very byte being pushed this cycle
    if (!cmd_flag_nxt)
      cmd_dout_nxt = 8'h00;
    else if (push && (rptr_nxt == wptr))
      cmd_dout_nxt = main_din;
    else
      cmd_dout_nxt = mem[rptr_nxt[FIFO_AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      wptr <= wptr_nxt;
      rptr <= rptr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[FIFO_AW-1:0]] <= main_din;
  end
`else
  always_comb begin
    ovf          = main_wr && snd_flag && !snd_rd;
    cmd_dout_nxt = main_wr ? main_din : snd_dout;
    cmd_flag_nxt = main_wr ? 1'b1 : (snd_rd ? 1'b0 : snd_flag);
    busy_nxt     = cmd_flag_nxt;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      snd_dout  <= 8'h00;
      snd_flag  <= 1'b0;
      main_busy <= 1'b0;
      ovf_cnt   <= 8'h00;
      main_dout <= 8'h00;
      main_flag <= 1'b0;
    end else begin
      snd_dout  <= cmd_dout_nxt;
      snd_flag  <= cmd_flag_nxt;
      main_busy <= busy_nxt;
      if (ovf && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
      if (snd_wr) begin
        main_dout <= snd_din;
        main_flag <= 1'b1;
      end else if (main_rd) begin
        main_flag <= 1'b0;
      end
    end
  end

  assign fire = (state == IDLE) && pend && nmi_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      pend      <= 1'b0;
      snd_nmi_n <= 1'b1;
    end else begin
      // A write in the same cycle as the pulse launch re-arms pend
      if (main_wr)   pend <= 1'b1;
      else if (fire) pend <= 1'b0;
      case (state)
        IDLE: if (fire) begin
          state     <= PULSE;
          cnt       <= CNT_INIT;
          snd_nmi_n <= 1'b0;
        end
        PULSE: if (cnt == 4'd0) begin
          state     <= WAIT;
          snd_nmi_n <= 1'b1;
        end else begin
          cnt <= cnt - 4'd1;
        end
        WAIT: if (!snd_flag) state <= IDLE;
        default: begin
          state     <= IDLE;
          snd_nmi_n <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
